// File: rtl/count_extender_if.sv
// Wrap-event stream carried from count_extender to its consumer.
// The producer drives valid/data, the consumer drives ready.
interface count_extender_if #(
    parameter int HI_WIDTH = 4
) ();
    logic              evt_valid;
    logic              evt_ready;
    logic [HI_WIDTH:0] evt_data;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/count_extender.sv
// count_extender: extends a free-running 4-bit ripple count with an
// HI_WIDTH-bit upper count by watching for 15->0 / 0->15 wraps between two
// registered samples. Wraps are also queued as events in a 2-entry FIFO.
module count_extender #(
    parameter int HI_WIDTH = 4
) (
    input  logic                  Clk,
    input  logic                  rst,
    input  logic [3:0]            Count,
    input  logic                  up_down,
    input  logic [4+HI_WIDTH-1:0] thresh,
    output logic [4+HI_WIDTH-1:0] ext_count,
    output logic                  wrap_up,
    output logic                  wrap_dn,
    output logic                  match,
    output logic                  jump_err,
    output logic                  dir_err,
    output logic                  evt_ovf,
    count_extender_if.master      evt
);
    localparam int DW = HI_WIDTH + 1;

    // Sample pipeline: s1 is the newest sample, s2 the previous one.
    logic [3:0]          s1_count_r, s2_count_r;
    logic                s1_dir_r;
    logic                v1_r, v2_r;
    logic [HI_WIDTH-1:0] hi_r;
    logic                wrap_up_r, wrap_dn_r;
    logic                jump_err_r, dir_err_r, evt_ovf_r;

    // Event FIFO storage.
    logic [DW-1:0]       fifo_mem_r [0:1];
    logic                wr_ptr_r, rd_ptr_r;
    logic [1:0]          fifo_cnt_r;

    // Classification / next-state signals.
    logic                cmp_en_s, hold_s, step_up_s, step_dn_s, jump_s;
    logic                wrap_up_s, wrap_dn_s, dir_bad_s;
    logic [HI_WIDTH-1:0] hi_next_s;
    logic                push_s, pop_s, full_s, push_ok_s, drop_s;
    logic [DW-1:0]       push_data_s;
    logic [1:0]          fifo_cnt_next_s;

    // +1 modulo 16 from old to new.
    function automatic logic is_step_up(input logic [3:0] old_v, input logic [3:0] new_v);
        return (new_v == (old_v + 4'd1));
    endfunction

    // -1 modulo 16 from old to new.
    function automatic logic is_step_dn(input logic [3:0] old_v, input logic [3:0] new_v);
        return (new_v == (old_v - 4'd1));
    endfunction

    // Classify the s2->s1 transition and derive hi / FIFO next-state.
    always_comb begin
        cmp_en_s  = v1_r & v2_r;
        hold_s    = 1'b0;
        step_up_s = 1'b0;
        step_dn_s = 1'b0;
        jump_s    = 1'b0;
        if (cmp_en_s) begin
            hold_s    = (s1_count_r == s2_count_r);
            step_up_s = is_step_up(s2_count_r, s1_count_r);
            step_dn_s = is_step_dn(s2_count_r, s1_count_r);
            jump_s    = ~hold_s & ~step_up_s & ~step_dn_s;
        end else begin
            hold_s    = 1'b0;
            step_up_s = 1'b0;
            step_dn_s = 1'b0;
            jump_s    = 1'b0;
        end

        wrap_up_s = step_up_s & (s2_count_r == 4'hF);
        wrap_dn_s = step_dn_s & (s2_count_r == 4'h0);
        dir_bad_s = (step_up_s & ~s1_dir_r) | (step_dn_s & s1_dir_r);

        if (wrap_up_s) begin
            hi_next_s = hi_r + HI_WIDTH'(1'b1);
        end else if (wrap_dn_s) begin
            hi_next_s = hi_r - HI_WIDTH'(1'b1);
        end else begin
            hi_next_s = hi_r;
        end

        // A push while full is still accepted if the same edge pops.
        push_s      = wrap_up_s | wrap_dn_s;
        push_data_s = {wrap_up_s, hi_next_s};
        pop_s       = (fifo_cnt_r != 2'd0) & evt.evt_ready;
        full_s      = (fifo_cnt_r == 2'd2);
        push_ok_s   = push_s & (~full_s | pop_s);
        drop_s      = push_s & full_s & ~pop_s;

        case ({push_ok_s, pop_s})
            2'b10:   fifo_cnt_next_s = fifo_cnt_r + 2'd1;
            2'b01:   fifo_cnt_next_s = fifo_cnt_r - 2'd1;
            default: fifo_cnt_next_s = fifo_cnt_r;
        endcase
    end

    // Capture Count/up_down into s1, shift s1 into s2, track validity.
    always_ff @(posedge Clk) begin
        if (rst) begin
            s1_count_r <= 4'd0;
            s2_count_r <= 4'd0;
            s1_dir_r   <= 1'b0;
            v1_r       <= 1'b0;
            v2_r       <= 1'b0;
        end else begin
            s1_count_r <= Count;
            s1_dir_r   <= up_down;
            s2_count_r <= s1_count_r;
            v1_r       <= 1'b1;
            v2_r       <= v1_r;
        end
    end

    // Upper count, wrap pulses and sticky jump/direction errors.
    always_ff @(posedge Clk) begin
        if (rst) begin
            hi_r       <= {HI_WIDTH{1'b0}};
            wrap_up_r  <= 1'b0;
            wrap_dn_r  <= 1'b0;
            jump_err_r <= 1'b0;
            dir_err_r  <= 1'b0;
        end else begin
            hi_r       <= hi_next_s;
            wrap_up_r  <= wrap_up_s;
            wrap_dn_r  <= wrap_dn_s;
            jump_err_r <= jump_err_r | jump_s;
            dir_err_r  <= dir_err_r | dir_bad_s;
        end
    end

    // Two-entry wrap-event FIFO with sticky overflow flag.
    always_ff @(posedge Clk) begin
        if (rst) begin
            fifo_mem_r[0] <= {DW{1'b0}};
            fifo_mem_r[1] <= {DW{1'b0}};
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            fifo_cnt_r    <= 2'd0;
            evt_ovf_r     <= 1'b0;
        end else begin
            if (push_ok_s) begin
                fifo_mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            fifo_cnt_r <= fifo_cnt_next_s;
            evt_ovf_r  <= evt_ovf_r | drop_s;
        end
    end

    assign ext_count     = {hi_r, s2_count_r};
    assign match         = (ext_count == thresh);
    assign wrap_up       = wrap_up_r;
    assign wrap_dn       = wrap_dn_r;
    assign jump_err      = jump_err_r;
    assign dir_err       = dir_err_r;
    assign evt_ovf       = evt_ovf_r;
    assign evt.evt_valid = (fifo_cnt_r != 2'd0);
    assign evt.evt_data  = fifo_mem_r[rd_ptr_r];
endmodule

// File: tb/tb_count_extender.sv
// Testbench for count_extender: scenario tasks with a queue of expected
// wrap events compared as the FIFO hands them out.
module tb_count_extender;
    localparam int HW = 4;

    logic          Clk;
    logic          rst;
    logic [3:0]    Count;
    logic          up_down;
    logic [7:0]    thresh;
    logic [7:0]    ext_count;
    logic          wrap_up, wrap_dn, match, jump_err, dir_err, evt_ovf;

    count_extender_if #(.HI_WIDTH(HW)) evt_if ();

    count_extender #(.HI_WIDTH(HW)) dut (
        .Clk       (Clk),
        .rst       (rst),
        .Count     (Count),
        .up_down   (up_down),
        .thresh    (thresh),
        .ext_count (ext_count),
        .wrap_up   (wrap_up),
        .wrap_dn   (wrap_dn),
        .match     (match),
        .jump_err  (jump_err),
        .dir_err   (dir_err),
        .evt_ovf   (evt_ovf),
        .evt       (evt_if)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         up_pulses = 0;
    int         dn_pulses = 0;
    logic [4:0] exp_q[$];
    logic [4:0] exp_v;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        Count = 4'd0;
        up_down = 1'b1;
        evt_if.evt_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        up_pulses = 0;
        dn_pulses = 0;
        tick();
        tick();
    endtask

    // Hold one Count value for 4 clocks, counting wrap pulses.
    task automatic run_step(input logic [3:0] v, input logic dir);
        Count = v;
        up_down = dir;
        repeat (4) begin
            tick();
            if (wrap_up) up_pulses++;
            if (wrap_dn) dn_pulses++;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (ext_count !== 8'h00) begin n_err++; $display("FAIL reset_ext: got %h want 00", ext_count); end
        n_cmp++; if ({wrap_up, wrap_dn} !== 2'b00) begin n_err++; $display("FAIL reset_wrap: got %b want 00", {wrap_up, wrap_dn}); end
        n_cmp++; if ({jump_err, dir_err, evt_ovf} !== 3'b000) begin n_err++; $display("FAIL reset_err: got %b want 000", {jump_err, dir_err, evt_ovf}); end
        n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", evt_if.evt_valid); end
        n_cmp++; if (match !== 1'b1) begin n_err++; $display("FAIL reset_match0: got %b want 1", match); end
        thresh = 8'h01;
        #1;
        n_cmp++; if (match !== 1'b0) begin n_err++; $display("FAIL reset_match1: got %b want 0", match); end
        thresh = 8'h00;
    endtask

    task automatic test_up_wrap();
        apply_reset();
        for (int i = 1; i <= 15; i++) run_step(4'(i), 1'b1);
        n_cmp++; if (ext_count !== 8'h0F) begin n_err++; $display("FAIL up_pre_ext: got %h want 0F", ext_count); end
        n_cmp++; if (up_pulses !== 0) begin n_err++; $display("FAIL up_pre_pulses: got %0d want 0", up_pulses); end
        exp_q.push_back({1'b1, 4'd1});
        run_step(4'd0, 1'b1);
        n_cmp++; if (up_pulses !== 1 || dn_pulses !== 0) begin n_err++; $display("FAIL up_pulses: got %0d/%0d want 1/0", up_pulses, dn_pulses); end
        n_cmp++; if (ext_count !== 8'h10) begin n_err++; $display("FAIL up_ext: got %h want 10", ext_count); end
        n_cmp++; if (evt_if.evt_valid !== 1'b1) begin n_err++; $display("FAIL up_valid: got %b want 1", evt_if.evt_valid); end
        evt_if.evt_ready = 1'b1;
        exp_v = exp_q.pop_front();
        n_cmp++; if (evt_if.evt_data !== exp_v) begin n_err++; $display("FAIL up_data: got %b want %b", evt_if.evt_data, exp_v); end
        tick();
        evt_if.evt_ready = 1'b0;
        n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_err++; $display("FAIL up_drained: got %b want 0", evt_if.evt_valid); end
        n_cmp++; if ({jump_err, dir_err, evt_ovf} !== 3'b000) begin n_err++; $display("FAIL up_err: got %b want 000", {jump_err, dir_err, evt_ovf}); end
    endtask

    task automatic test_down_wrap();
        apply_reset();
        exp_q.push_back({1'b0, 4'hF});
        run_step(4'hF, 1'b0);
        n_cmp++; if (dn_pulses !== 1 || up_pulses !== 0) begin n_err++; $display("FAIL dn_pulses: got %0d/%0d want 1/0", dn_pulses, up_pulses); end
        n_cmp++; if (ext_count !== 8'hFF) begin n_err++; $display("FAIL dn_ext: got %h want FF", ext_count); end
        n_cmp++; if ({jump_err, dir_err, evt_ovf} !== 3'b000) begin n_err++; $display("FAIL dn_err: got %b want 000", {jump_err, dir_err, evt_ovf}); end
        evt_if.evt_ready = 1'b1;
        exp_v = exp_q.pop_front();
        n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== exp_v) begin n_err++; $display("FAIL dn_data: got v=%b %b want v=1 %b", evt_if.evt_valid, evt_if.evt_data, exp_v); end
        tick();
        evt_if.evt_ready = 1'b0;
        n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_err++; $display("FAIL dn_drained: got %b want 0", evt_if.evt_valid); end
    endtask

    task automatic test_errors();
        apply_reset();
        for (int i = 1; i <= 3; i++) run_step(4'(i), 1'b1);
        n_cmp++; if (jump_err !== 1'b0) begin n_err++; $display("FAIL err_nojump: got %b want 0", jump_err); end
        run_step(4'd9, 1'b1);
        n_cmp++; if (jump_err !== 1'b1) begin n_err++; $display("FAIL err_jump: got %b want 1", jump_err); end
        n_cmp++; if (ext_count !== 8'h09) begin n_err++; $display("FAIL err_jump_hi: got %h want 09", ext_count); end
        run_step(4'd4, 1'b1);
        n_cmp++; if (jump_err !== 1'b1 || dir_err !== 1'b0) begin n_err++; $display("FAIL err_sticky: got j=%b d=%b want j=1 d=0", jump_err, dir_err); end
        run_step(4'd5, 1'b0);
        n_cmp++; if (dir_err !== 1'b1) begin n_err++; $display("FAIL err_dir: got %b want 1", dir_err); end
        n_cmp++; if (ext_count !== 8'h05 || up_pulses !== 0) begin n_err++; $display("FAIL err_ext: got %h/%0d want 05/0", ext_count, up_pulses); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int w = 1; w <= 3; w++) begin
            if (w <= 2) exp_q.push_back({1'b1, 4'(w)});
            for (int i = 1; i <= 16; i++) run_step(4'(i), 1'b1);
        end
        n_cmp++; if (up_pulses !== 3 || ext_count !== 8'h30) begin n_err++; $display("FAIL ovf_count: got %0d/%h want 3/30", up_pulses, ext_count); end
        n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_flags: got v=%b o=%b want 1/1", evt_if.evt_valid, evt_ovf); end
        n_cmp++; if (evt_if.evt_data !== exp_q[0]) begin n_err++; $display("FAIL ovf_stable: got %b want %b", evt_if.evt_data, exp_q[0]); end
        evt_if.evt_ready = 1'b1;
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
            exp_v = exp_q.pop_front();
            n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== exp_v) begin n_err++; $display("FAIL ovf_drain: got v=%b %b want v=1 %b", evt_if.evt_valid, evt_if.evt_data, exp_v); end
            tick();
        end
        evt_if.evt_ready = 1'b0;
        n_cmp++; if (evt_if.evt_valid !== 1'b0 || evt_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_end: got v=%b o=%b want 0/1", evt_if.evt_valid, evt_ovf); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int w = 1; w <= 2; w++) begin
            exp_q.push_back({1'b1, 4'(w)});
            for (int i = 1; i <= 16; i++) run_step(4'(i), 1'b1);
        end
        for (int i = 1; i <= 15; i++) run_step(4'(i), 1'b1);
        Count = 4'd0;
        exp_q.push_back({1'b1, 4'd3});
        tick();
        evt_if.evt_ready = 1'b1;
        exp_v = exp_q.pop_front();
        n_cmp++; if (evt_if.evt_data !== exp_v) begin n_err++; $display("FAIL b2b_first: got %b want %b", evt_if.evt_data, exp_v); end
        tick();
        evt_if.evt_ready = 1'b0;
        n_cmp++; if (wrap_up !== 1'b1 || ext_count !== 8'h30) begin n_err++; $display("FAIL b2b_wrap: got %b/%h want 1/30", wrap_up, ext_count); end
        n_cmp++; if (evt_ovf !== 1'b0 || evt_if.evt_valid !== 1'b1) begin n_err++; $display("FAIL b2b_flags: got o=%b v=%b want 0/1", evt_ovf, evt_if.evt_valid); end
        evt_if.evt_ready = 1'b1;
        for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
            exp_v = exp_q.pop_front();
            n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== exp_v) begin n_err++; $display("FAIL b2b_drain: got v=%b %b want v=1 %b", evt_if.evt_valid, evt_if.evt_data, exp_v); end
            tick();
        end
        evt_if.evt_ready = 1'b0;
        n_cmp++; if (evt_if.evt_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", evt_if.evt_valid); end
    endtask

    task automatic test_match();
        apply_reset();
        thresh = 8'h12;
        for (int i = 1; i <= 16; i++) run_step(4'(i), 1'b1);
        run_step(4'd1, 1'b1);
        n_cmp++; if (ext_count !== 8'h11 || match !== 1'b0) begin n_err++; $display("FAIL match_11: got %h/%b want 11/0", ext_count, match); end
        run_step(4'd2, 1'b1);
        n_cmp++; if (ext_count !== 8'h12 || match !== 1'b1) begin n_err++; $display("FAIL match_12: got %h/%b want 12/1", ext_count, match); end
        run_step(4'd3, 1'b1);
        n_cmp++; if (ext_count !== 8'h13 || match !== 1'b0) begin n_err++; $display("FAIL match_13: got %h/%b want 13/0", ext_count, match); end
        thresh = 8'h00;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        evt_if.evt_ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            for (int i = 1; i <= 16; i++) run_step(4'(i), 1'b1);
        end
        n_cmp++; if (evt_if.evt_valid !== 1'b0 || ext_count !== 8'h40) begin n_err++; $display("FAIL mid_pre4: got v=%b %h want 0/40", evt_if.evt_valid, ext_count); end
        evt_if.evt_ready = 1'b0;
        exp_q.push_back({1'b1, 4'd5});
        for (int i = 1; i <= 16; i++) run_step(4'(i), 1'b1);
        run_step(4'd7, 1'b1);
        n_cmp++; if (ext_count !== 8'h57 || jump_err !== 1'b1) begin n_err++; $display("FAIL mid_pre: got %h/%b want 57/1", ext_count, jump_err); end
        n_cmp++; if (evt_if.evt_valid !== 1'b1 || evt_if.evt_data !== exp_q[0]) begin n_err++; $display("FAIL mid_fifo: got v=%b %b want v=1 %b", evt_if.evt_valid, evt_if.evt_data, exp_q[0]); end
        rst = 1'b1;
        Count = 4'd0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        n_cmp++; if (ext_count !== 8'h00 || {wrap_up, wrap_dn} !== 2'b00) begin n_err++; $display("FAIL mid_clear: got %h/%b want 00/00", ext_count, {wrap_up, wrap_dn}); end
        n_cmp++; if ({jump_err, dir_err, evt_ovf, evt_if.evt_valid} !== 4'b0000) begin n_err++; $display("FAIL mid_flags: got %b want 0000", {jump_err, dir_err, evt_ovf, evt_if.evt_valid}); end
        up_pulses = 0;
        dn_pulses = 0;
        run_step(4'd0, 1'b1);
        run_step(4'd0, 1'b1);
        n_cmp++; if (up_pulses !== 0 || dn_pulses !== 0 || ext_count !== 8'h00) begin n_err++; $display("FAIL mid_post: got %0d/%0d/%h want 0/0/00", up_pulses, dn_pulses, ext_count); end
        n_cmp++; if (jump_err !== 1'b0) begin n_err++; $display("FAIL mid_nojump: got %b want 0", jump_err); end
    endtask

    initial begin
        rst = 1'b1;
        Count = 4'd0;
        up_down = 1'b1;
        thresh = 8'h00;
        evt_if.evt_ready = 1'b0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_errors();
        test_overflow();
        test_back_to_back();
        test_match();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/count_extender.md
COUNT_EXTENDER -- requirements
Module: count_extender

Interface
REQ-001 SHALL have parameter HI_WIDTH, default 4, width of the upper extension count.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port Count  input  4  ripple-counter value to be extended.
REQ-005 SHALL have port up_down  input  1  counter direction setting (1 = up, 0 = down).
REQ-006 SHALL have port thresh  input  4+HI_WIDTH  compare value for match.
REQ-007 SHALL have port ext_count  output  4+HI_WIDTH  extended count {hi, low nibble}.
REQ-008 SHALL have ports wrap_up, wrap_dn  output  1 each  one-cycle wrap pulses.
REQ-009 SHALL have port match  output  1  ext_count equals thresh.
REQ-010 SHALL have ports jump_err, dir_err, evt_ovf  output  1 each  sticky error flags.
REQ-011 SHALL have ports evt_valid (out, 1), evt_ready (in, 1), evt_data (out, 1+HI_WIDTH) for the wrap-event stream.

Function
REQ-012 SHALL register Count and up_down into stage s1 each edge, and copy s1 into stage s2 each edge.
REQ-013 SHALL track sample validity with flags v1 and v2, which follow s1 and s2.
- Comparison is enabled only when v1 and v2 are both set before the edge.
REQ-014 SHALL classify each enabled comparison of s2 (old) against s1 (new) as one of:
- hold (equal)
- +1 mod 16
- -1 mod 16
- jump (any other difference)
REQ-015 SHALL register wrap_up=1 for exactly one cycle when s2=15 and s1=0.
REQ-016 SHALL register wrap_dn=1 for exactly one cycle when s2=0 and s1=15.
REQ-017 SHALL increment hi on wrap_up and decrement hi on wrap_dn, modulo 2^HI_WIDTH.
- hi update occurs on the same edge as the pulse.
REQ-018 SHALL drive ext_count = {hi, s2}, giving 2-edge latency from stable Count to ext_count.
REQ-019 SHALL set jump_err on any jump and hold it until rst; hi is unchanged on a jump.
REQ-020 SHALL set dir_err (sticky) on a +1 step while s1 up_down=0, or a -1 step while s1 up_down=1.
REQ-021 SHALL drive match combinationally as (ext_count == thresh).
REQ-022 SHALL push one entry into a 2-entry FIFO on each wrap.
- Entry is evt_data = {dir, hi-after-update}, where dir=1 for up and dir=0 for down.
- The entry is pushed on the same edge as the wrap pulse.
REQ-023 SHALL assert evt_valid whenever the FIFO is non-empty.
- evt_data is the oldest entry.
- evt_data stays stable while evt_valid=1 and evt_ready=0.
REQ-024 SHALL pop one entry on each edge where evt_valid=1 and evt_ready=1.
REQ-025 SHALL handle a push and a pop on the same edge when full by accepting both (the pop frees the slot).
- Occupancy stays 2.
REQ-026 SHALL drop a push when full with no pop, and set evt_ovf (sticky until rst).
REQ-027 SHALL preserve FIFO entry order across wraps in both directions.

Reset
REQ-028 SHALL give rst priority over all other activity on any edge.
REQ-029 SHALL, while rst=1 at an edge, clear all of the following:
- s1, s2, v1, v2, hi
- wrap_up, wrap_dn
- jump_err, dir_err, evt_ovf
- FIFO contents (evt_valid=0)
- After reset, ext_count=0 and match follows thresh==0.
REQ-030 SHALL suppress classification until two post-reset samples have been captured, so no wrap, jump or error is flagged from pre-reset state.

Verification
REQ-031 SHALL cover up wrap:
- Stimulus: up_down=1; Count steps 0..15 then 0, one step per 4 Clk.
- Response: single wrap_up pulse, hi=1, ext_count=0x10, evt_data=0b1_0001.
REQ-032 SHALL cover down wrap:
- Stimulus: from reset, up_down=0, Count 0 -> 15.
- Response: single wrap_dn pulse, ext_count=0xFF, evt_data=0b0_1111, no errors.
REQ-033 SHALL cover jump and direction errors:
- Stimulus: Count 3 -> 9.
- Response: jump_err=1 and stays 1, hi unchanged.
- Stimulus: Count 4 -> 5 with up_down=0.
- Response: dir_err=1.
REQ-034 SHALL cover FIFO overflow:
- Stimulus: evt_ready=0 through three up wraps.
- Response: evt_valid=1, evt_ovf=1.
- Stimulus: then evt_ready=1.
- Response: entries {1,1} then {1,2} delivered in order, evt_valid=0 after.
REQ-035 SHALL cover threshold match:
- Stimulus: thresh=0x12; count up to ext_count=0x12.
- Response: match=1 in that cycle only, 0 at 0x11 and 0x13.
REQ-036 SHALL cover reset mid-operation:
- Stimulus: rst asserted for 1 edge with hi=5, FIFO holding 1 entry, jump_err=1.
- Response: all cleared next cycle.
- Stimulus: Count held at 0 after release.
- Response: no wrap pulse, ext_count=0x00.
